dsram_responder: RTL and testbench
==================================

Name: dsram_responder

Overview:
- Data-side SRAM responder: the slave end of the data_sram_en/wen/addr/wdata interface driven by the execute stage.
- Word-organised synchronous RAM with byte-lane write enables and 1-cycle read latency.
- Optional programmable extra wait states. During wait states it raises stallreq to the pipeline stall controller, which holds the request stable until the access is performed.
- Sits beside the memory stage; data_sram_rdata feeds MEM load-result selection.

Parameters:
- ADDR_W, 10, word-address bits; depth = 2**ADDR_W words (4 KiB at default).
- WAIT_CYC, 0, extra wait-state cycles per access (0..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- data_sram_en  in  1  access request this cycle.
- data_sram_wen  in  4  byte write enables; bit i writes wdata[8i+7:8i]; 0000 = read.
- data_sram_addr  in  32  byte address; word index = addr[ADDR_W+1:2]; addr[1:0] ignored.
- data_sram_wdata  in  32  write data, pre-aligned to byte lanes by the initiator.
- data_sram_rdata  out  32  read data.
- resp_valid  out  1  one-cycle pulse: access completed (read data valid, or write committed).
- stallreq  out  1  request pipeline stall while a wait-state access is pending.

Behaviour:
- Reset: state IDLE, wait counter 0, data_sram_rdata 0, resp_valid 0, stallreq 0. RAM contents are not cleared (undefined until written).
- Address wrap: upper address bits above ADDR_W+1 are ignored; addresses alias modulo depth. No error is flagged.
- WAIT_CYC = 0: no FSM activity. On any cycle with en=1 the access is performed at that rising edge.
  - Write: each enabled byte lane is updated.
  - Read: rdata = mem[idx] from the next cycle.
  - resp_valid = 1 in the next cycle. stallreq stays 0.
  - Back-to-back requests are accepted every cycle.
- WAIT_CYC > 0, FSM states IDLE, WAIT, DONE:
  - IDLE: on en=1, latch addr/wen/wdata, load counter = WAIT_CYC-1, go WAIT. stallreq is combinationally 1 in this cycle (en & IDLE).
  - WAIT: stallreq = 1. Counter decrements each cycle. When counter = 0, perform the latched access at that edge and go DONE. Inputs are ignored in WAIT; only latched values are used.
  - DONE: stallreq = 0, resp_valid = 1, rdata valid if the access was a read. Next state IDLE. A new en in DONE is not accepted; it is accepted on the following IDLE cycle.
  - Total: request cycle to resp_valid = WAIT_CYC+1 cycles; stallreq is high for WAIT_CYC+1 cycles, counting the request cycle.
- Writes never modify data_sram_rdata; it holds the last read result.
- Partial writes (e.g. wen = 0011) leave unselected bytes unchanged. wen = 1111 is a full-word write.
- Read-after-write to the same word in consecutive accesses returns the new data; there is no bypass hazard because accesses are serialised.
- Reset mid-access: a pending latched write is dropped (RAM unchanged), the FSM returns to IDLE, and stallreq drops the cycle after rst is sampled.
- en = 0 is a no-op in all states except WAIT and DONE, which are unaffected by en.

Decomposition:
- Shared defines header: add the DSRAM_WAIT_CYC default and the wen encoding constants (WEN_BYTE = 0001 shifted, WEN_HALF = 0011 shifted, WEN_WORD = 1111). Define them alongside the existing StallBus/Stop macros so the stall controller and MEM agree.
- One sub-module: dsram_bytemem — the RAM array with a 4-lane byte-write port and a registered read port. The responder wraps it with the FSM, counter, latch and handshake outputs.

Test Plan:
- WAIT_CYC=0: write addr 0x10, wen 1111, wdata 0xDEADBEEF; next cycle read 0x10 -> rdata 0xDEADBEEF one cycle after the read request, resp_valid pulses, stallreq stays 0.
- Byte lanes: after the above, write 0x10, wen 0010, wdata 0x0000AA00; read -> 0xDEADAAEF. Then read 0x13 -> same word (addr[1:0] ignored).
- Wrap: ADDR_W=10, write 0x1000 with 0x12345678; read 0x0000 -> 0x12345678.
- WAIT_CYC=3: read request at cycle t -> stallreq high t..t+3, resp_valid and rdata valid at t+4. Changing addr/en during t+1..t+3 has no effect on the result.
- Reset mid-access: WAIT_CYC=3, write 0x20 = 0x55 at cycle t, assert rst at t+1 -> FSM IDLE, stallreq 0 at t+2, rdata 0. A subsequent read of 0x20 returns its prior value, not 0x55.
- Back-to-back, WAIT_CYC=0: write then read the same word on consecutive cycles -> the read returns the new data; resp_valid is high for two consecutive cycles.

Source files
------------

// File: rtl/dsram_responder_pkg.sv
// ---------------------------------------------------------------------------
// dsram_responder_pkg
// Shared definitions for the data-side SRAM responder and its initiators
// (execute stage, MEM load selection, stall controller):
//   - default geometry and wait-state count
//   - byte-write-enable encodings (base patterns, shift left by byte lane)
//   - responder FSM state type
//   - small helpers on the write-enable field
// ---------------------------------------------------------------------------
package dsram_responder_pkg;

  // Default word-address width (1024 words = 4 KiB) and extra wait states.
  localparam int DSRAM_ADDR_W   = 10;
  localparam int DSRAM_WAIT_CYC = 0;

  // Wait-state counter width; covers WAIT_CYC up to 15.
  localparam int WAIT_CNT_W = 4;

  // Byte-lane write-enable encodings. BYTE and HALF are base patterns that
  // the initiator shifts to the addressed lane(s); READ means no lane written.
  localparam logic [3:0] WEN_READ = 4'b0000;
  localparam logic [3:0] WEN_BYTE = 4'b0001;
  localparam logic [3:0] WEN_HALF = 4'b0011;
  localparam logic [3:0] WEN_WORD = 4'b1111;

  // Responder FSM states, only used when extra wait states are configured.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } dsram_state_e;

  // An access with no byte lane enabled is a read.
  function automatic logic wen_is_read(input logic [3:0] wen);
    return (wen == WEN_READ);
  endfunction

  // Place a base enable pattern onto the lane selected by the low address bits.
  function automatic logic [3:0] wen_at_lane(input logic [3:0] base,
                                             input logic [1:0] lane);
    return 4'(base << lane);
  endfunction

endpackage

// File: rtl/dsram_responder_bytemem.sv
// ---------------------------------------------------------------------------
// dsram_responder_bytemem
// Word-organised synchronous RAM with a 4-lane byte-write port and a
// registered read port (1-cycle read latency). The array itself has no reset;
// only the read-data register is cleared.
//
// Ports:
//   clk    in   1       clock
//   rst    in   1       synchronous active-high reset (clears rdata, blocks
//                       any access presented in the same cycle)
//   acc    in   1       perform the access at this rising edge
//   wen    in   4       byte-lane write enables, 0000 = read
//   idx    in   ADDR_W  word index
//   wdata  in   32      lane-aligned write data
//   rdata  out  32      read data, updated only by reads
// ---------------------------------------------------------------------------
module dsram_responder_bytemem
  import dsram_responder_pkg::*;
#(
  parameter int ADDR_W = DSRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc,
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem_r [0:DEPTH-1];
  logic        wr_s;
  logic        rd_s;

  // Reset wins over a coincident access so a dropped write never lands.
  assign wr_s = acc & ~rst & ~wen_is_read(wen);
  assign rd_s = acc & ~rst &  wen_is_read(wen);

  // Byte-lane writes into the array; unselected lanes keep their contents.
  always_ff @(posedge clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (wr_s && wen[lane]) begin
        mem_r[idx][8*lane +: 8] <= wdata[8*lane +: 8];
      end
    end
  end

  // Registered read port; writes leave the last read result in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'd0;
    end else if (rd_s) begin
      rdata <= mem_r[idx];
    end
  end

endmodule

// File: rtl/dsram_responder.sv
// ---------------------------------------------------------------------------
// dsram_responder
// Slave end of the execute-stage data SRAM interface. Performs word-organised
// byte-enabled accesses with 1-cycle read latency. With WAIT_CYC > 0 each
// access is latched, held for WAIT_CYC extra cycles while stallreq freezes
// the pipeline, then performed; resp_valid pulses one cycle later.
//
// Ports:
//   clk              in   1   clock
//   rst              in   1   synchronous active-high reset
//   data_sram_en     in   1   access request this cycle
//   data_sram_wen    in   4   byte write enables, 0000 = read
//   data_sram_addr   in   32  byte address; word index = addr[ADDR_W+1:2]
//   data_sram_wdata  in   32  lane-aligned write data
//   data_sram_rdata  out  32  read data (holds the last read result)
//   resp_valid       out  1   one-cycle pulse: access completed
//   stallreq         out  1   stall request while a wait-state access pends
// ---------------------------------------------------------------------------
module dsram_responder
  import dsram_responder_pkg::*;
#(
  parameter int ADDR_W   = DSRAM_ADDR_W,
  parameter int WAIT_CYC = DSRAM_WAIT_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        resp_valid,
  output logic        stallreq
);

  logic [ADDR_W-1:0] in_idx_s;
  logic              unused_addr_s;

  // Access presented to the RAM this cycle (from inputs or from the latch).
  logic              acc_s;
  logic [3:0]        acc_wen_s;
  logic [ADDR_W-1:0] acc_idx_s;
  logic [31:0]       acc_wdata_s;

  logic              resp_valid_r;
  logic              stallreq_s;

  // Upper bits alias modulo depth and the byte offset is ignored.
  assign in_idx_s      = data_sram_addr[ADDR_W+1:2];
  assign unused_addr_s = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  generate
    if (WAIT_CYC == 0) begin : g_direct

      assign acc_s       = data_sram_en;
      assign acc_wen_s   = data_sram_wen;
      assign acc_idx_s   = in_idx_s;
      assign acc_wdata_s = data_sram_wdata;
      assign stallreq_s  = 1'b0;

      // Every accepted request completes at its own edge; flag it next cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          resp_valid_r <= 1'b0;
        end else begin
          resp_valid_r <= data_sram_en;
        end
      end

    end else begin : g_fsm

      localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = WAIT_CNT_W'(WAIT_CYC - 1);
      localparam logic [WAIT_CNT_W-1:0] CNT_ZERO = WAIT_CNT_W'(0);
      localparam logic [WAIT_CNT_W-1:0] CNT_ONE  = WAIT_CNT_W'(1);

      dsram_state_e          state_r;
      dsram_state_e          state_nx;
      logic [WAIT_CNT_W-1:0] cnt_r;
      logic [WAIT_CNT_W-1:0] cnt_nx;
      logic                  latch_s;
      logic                  perform_s;

      logic [3:0]            wen_r;
      logic [ADDR_W-1:0]     idx_r;
      logic [31:0]           wdata_r;

      // FSM state and wait counter.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
        end else begin
          state_r <= state_nx;
          cnt_r   <= cnt_nx;
        end
      end

      // Request latch: the pipeline holds its inputs, but only these copies
      // are used so changes during the wait window cannot leak in.
      always_ff @(posedge clk) begin
        if (rst) begin
          wen_r   <= WEN_READ;
          idx_r   <= {ADDR_W{1'b0}};
          wdata_r <= 32'd0;
        end else if (latch_s) begin
          wen_r   <= data_sram_wen;
          idx_r   <= in_idx_s;
          wdata_r <= data_sram_wdata;
        end
      end

      // Next-state, counter and handshake decode.
      always_comb begin
        state_nx   = state_r;
        cnt_nx     = cnt_r;
        latch_s    = 1'b0;
        perform_s  = 1'b0;
        stallreq_s = 1'b0;
        case (state_r)
          ST_IDLE: begin
            if (data_sram_en) begin
              // Stall already in the request cycle so the pipeline freezes.
              state_nx   = ST_WAIT;
              cnt_nx     = CNT_LOAD;
              latch_s    = 1'b1;
              stallreq_s = 1'b1;
            end else begin
              state_nx = ST_IDLE;
            end
          end
          ST_WAIT: begin
            stallreq_s = 1'b1;
            if (cnt_r == CNT_ZERO) begin
              perform_s = 1'b1;
              state_nx  = ST_DONE;
            end else begin
              cnt_nx = cnt_r - CNT_ONE;
            end
          end
          ST_DONE: begin
            // Response cycle; a new request here is only taken in IDLE.
            state_nx = ST_IDLE;
          end
          default: begin
            state_nx = ST_IDLE;
          end
        endcase
      end

      // resp_valid marks the DONE cycle, one edge after the access.
      always_ff @(posedge clk) begin
        if (rst) begin
          resp_valid_r <= 1'b0;
        end else begin
          resp_valid_r <= perform_s;
        end
      end

      assign acc_s       = perform_s;
      assign acc_wen_s   = wen_r;
      assign acc_idx_s   = idx_r;
      assign acc_wdata_s = wdata_r;

    end
  endgenerate

  dsram_responder_bytemem #(
    .ADDR_W (ADDR_W)
  ) u_bytemem (
    .clk   (clk),
    .rst   (rst),
    .acc   (acc_s),
    .wen   (acc_wen_s),
    .idx   (acc_idx_s),
    .wdata (acc_wdata_s),
    .rdata (data_sram_rdata)
  );

  assign resp_valid = resp_valid_r;
  assign stallreq   = stallreq_s;

endmodule

// File: tb/tb_dsram_responder.sv
// ---------------------------------------------------------------------------
// tb_dsram_responder
// Two responders side by side: dut0 with no wait states, dut3 with three.
// A word-array reference model tracks memory contents and the expected read
// register of each instance.
// ---------------------------------------------------------------------------
module tb_dsram_responder;
  import dsram_responder_pkg::*;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int WC    = 3;

  logic        clk = 1'b0;
  logic        rst;

  logic        en0, en3;
  logic [3:0]  wen0, wen3;
  logic [31:0] addr0, addr3, wdata0, wdata3;
  logic [31:0] rdata0, rdata3;
  logic        resp0, resp3, stall0, stall3;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m0 [0:DEPTH-1];
  logic [31:0] m3 [0:DEPTH-1];
  logic [31:0] exp_rd0;
  logic [31:0] exp_rd3;

  always #5 clk = ~clk;

  dsram_responder #(.ADDR_W(AW), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst),
    .data_sram_en(en0), .data_sram_wen(wen0), .data_sram_addr(addr0),
    .data_sram_wdata(wdata0), .data_sram_rdata(rdata0),
    .resp_valid(resp0), .stallreq(stall0)
  );

  dsram_responder #(.ADDR_W(AW), .WAIT_CYC(WC)) dut3 (
    .clk(clk), .rst(rst),
    .data_sram_en(en3), .data_sram_wen(wen3), .data_sram_addr(addr3),
    .data_sram_wdata(wdata3), .data_sram_rdata(rdata3),
    .resp_valid(resp3), .stallreq(stall3)
  );

  // ---------------- reference model ----------------
  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % 32'(DEPTH));
  endfunction

  function automatic logic [31:0] apply_wen(input logic [31:0] old,
                                            input logic [31:0] nw,
                                            input logic [3:0] wen);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (wen[b]) r[8*b +: 8] = nw[8*b +: 8];
    end
    return r;
  endfunction

  task automatic model0_step(input logic [3:0] wen, input logic [31:0] addr,
                             input logic [31:0] wdata);
    int i;
    i = widx(addr);
    if (wen == 4'b0000) exp_rd0 = m0[i];
    else m0[i] = apply_wen(m0[i], wdata, wen);
  endtask

  task automatic model3_step(input logic [3:0] wen, input logic [31:0] addr,
                             input logic [31:0] wdata);
    int i;
    i = widx(addr);
    if (wen == 4'b0000) exp_rd3 = m3[i];
    else m3[i] = apply_wen(m3[i], wdata, wen);
  endtask

  function automatic logic [3:0] rand_wen();
    case ($urandom_range(0, 5))
      0, 1:    return WEN_READ;
      2:       return wen_at_lane(WEN_BYTE, 2'($urandom_range(0, 3)));
      3:       return wen_at_lane(WEN_HALF, 2'(2 * $urandom_range(0, 1)));
      4:       return WEN_WORD;
      default: return 4'($urandom);
    endcase
  endfunction

  // Word 0..15 with random alias bits above the index and random byte offset.
  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) << 2)
        | 32'($urandom_range(0, 3));
    return a;
  endfunction

  // ---------------- drivers (called at a negedge, return at a negedge) ----------------
  task automatic access0(input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd,
                         output logic rsp, output logic stl);
    en0 = 1'b1; wen0 = wen; addr0 = addr; wdata0 = wdata;
    #1 stl = stall0;
    @(negedge clk);
    rd  = rdata0;
    rsp = resp0;
    stl = stl | stall0;
    model0_step(wen, addr, wdata);
  endtask

  // One full wait-state transaction: request cycle, WC wait cycles, DONE, IDLE.
  // Bit k of the vectors is sampled k cycles after the request cycle.
  task automatic access3(input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit scramble,
                         output logic [5:0] stl_v, output logic [5:0] rsp_v,
                         output logic [31:0] rd);
    en3 = 1'b1; wen3 = wen; addr3 = addr; wdata3 = wdata;
    #1;
    stl_v[0] = stall3; rsp_v[0] = resp3;
    for (int c = 1; c <= WC; c++) begin
      @(negedge clk);
      if (scramble) begin
        en3 = 1'($urandom_range(0, 1)); wen3 = 4'($urandom);
        addr3 = $urandom; wdata3 = $urandom;
      end
      #1;
      stl_v[c] = stall3; rsp_v[c] = resp3;
    end
    @(negedge clk);
    rd = rdata3;
    if (scramble) begin
      // A request offered during DONE must be ignored.
      en3 = 1'b1; wen3 = WEN_WORD; addr3 = $urandom; wdata3 = $urandom;
    end else begin
      en3 = 1'b0;
    end
    #1;
    stl_v[4] = stall3; rsp_v[4] = resp3;
    @(negedge clk);
    en3 = 1'b0;
    #1;
    stl_v[5] = stall3; rsp_v[5] = resp3;
    model3_step(wen, addr, wdata);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    en0 = 1'b0; wen0 = 4'd0; addr0 = 32'd0; wdata0 = 32'd0;
    en3 = 1'b0; wen3 = 4'd0; addr3 = 32'd0; wdata3 = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_rd0 = 32'd0; exp_rd3 = 32'd0;
    checks++; if (rdata0 !== 32'd0) begin failures++; $display("FAIL reset_rdata0 got=%h exp=%h", rdata0, 32'd0); end
    checks++; if (resp0 !== 1'b0) begin failures++; $display("FAIL reset_resp0 got=%b exp=0", resp0); end
    checks++; if (stall0 !== 1'b0) begin failures++; $display("FAIL reset_stall0 got=%b exp=0", stall0); end
    checks++; if (rdata3 !== 32'd0) begin failures++; $display("FAIL reset_rdata3 got=%h exp=%h", rdata3, 32'd0); end
    checks++; if (resp3 !== 1'b0) begin failures++; $display("FAIL reset_resp3 got=%b exp=0", resp3); end
    checks++; if (stall3 !== 1'b0) begin failures++; $display("FAIL reset_stall3 got=%b exp=0", stall3); end
  endtask

  task automatic test_basic0();
    logic [31:0] rd; logic rsp, stl;
    access0(WEN_WORD, 32'h10, 32'hDEADBEEF, rd, rsp, stl);
    checks++; if (rsp !== 1'b1) begin failures++; $display("FAIL b0_wr_resp got=%b exp=1", rsp); end
    checks++; if (stl !== 1'b0) begin failures++; $display("FAIL b0_wr_stall got=%b exp=0", stl); end
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL b0_wr_rdata_hold got=%h exp=%h", rd, 32'd0); end
    access0(WEN_READ, 32'h10, 32'h0BAD0BAD, rd, rsp, stl);
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL b0_read got=%h exp=%h", rd, 32'hDEADBEEF); end
    checks++; if (rsp !== 1'b1 || stl !== 1'b0) begin failures++; $display("FAIL b0_rd_hs got=%b%b exp=10", rsp, stl); end
    en0 = 1'b0;
    @(negedge clk);
    checks++; if (resp0 !== 1'b0) begin failures++; $display("FAIL b0_resp_pulse got=%b exp=0", resp0); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic rsp, stl;
    access0(4'b0010, 32'h10, 32'h0000AA00, rd, rsp, stl);
    access0(WEN_READ, 32'h10, 32'd0, rd, rsp, stl);
    checks++; if (rd !== 32'hDEADAAEF) begin failures++; $display("FAIL lane_rd got=%h exp=%h", rd, 32'hDEADAAEF); end
    access0(WEN_READ, 32'h13, 32'd0, rd, rsp, stl);
    checks++; if (rd !== 32'hDEADAAEF) begin failures++; $display("FAIL lane_rd_off3 got=%h exp=%h", rd, 32'hDEADAAEF); end
    en0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic rsp, stl;
    access0(WEN_WORD, 32'h1000, 32'h12345678, rd, rsp, stl);
    access0(WEN_READ, 32'h0000, 32'd0, rd, rsp, stl);
    checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL wrap_rd got=%h exp=%h", rd, 32'h12345678); end
    en0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic rsp1, rsp2, rsp3, stl;
    access0(WEN_WORD, 32'h44, 32'hCAFEF00D, rd, rsp1, stl);
    access0(WEN_READ, 32'h44, 32'd0, rd, rsp2, stl);
    checks++; if (rsp1 !== 1'b1 || rsp2 !== 1'b1) begin failures++; $display("FAIL b2b_resp got=%b%b exp=11", rsp1, rsp2); end
    checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL b2b_rd got=%h exp=%h", rd, 32'hCAFEF00D); end
    access0(wen_at_lane(WEN_HALF, 2'd2), 32'h46, 32'hBEEF0000, rd, rsp1, stl);
    access0(WEN_READ, 32'h44, 32'd0, rd, rsp3, stl);
    checks++; if (rd !== 32'hBEEFF00D) begin failures++; $display("FAIL b2b_half got=%h exp=%h", rd, 32'hBEEFF00D); end
    en0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random0();
    logic [31:0] rd; logic rsp, stl;
    logic [3:0] w; logic [31:0] a, d;
    for (int i = 0; i < 16; i++) access0(WEN_WORD, 32'(i * 4), $urandom, rd, rsp, stl);
    for (int n = 0; n < 100; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        en0 = 1'b0;
        @(negedge clk);
        checks++; if (resp0 !== 1'b0 || rdata0 !== exp_rd0) begin failures++; $display("FAIL rnd0_idle resp=%b rd=%h exp_rd=%h", resp0, rdata0, exp_rd0); end
      end else begin
        w = rand_wen(); a = rand_addr(); d = $urandom;
        access0(w, a, d, rd, rsp, stl);
        checks++; if (rsp !== 1'b1 || stl !== 1'b0 || rd !== exp_rd0) begin failures++; $display("FAIL rnd0 wen=%b addr=%h resp=%b stall=%b got=%h exp=%h", w, a, rsp, stl, rd, exp_rd0); end
      end
    end
    en0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wait_timing();
    logic [5:0] sv, rv; logic [31:0] rd;
    access3(WEN_WORD, 32'h10, 32'hA5A5_0F0F, 1'b0, sv, rv, rd);
    checks++; if (sv !== 6'b001111 || rv !== 6'b010000) begin failures++; $display("FAIL wait_wr_timing stall=%b resp=%b exp=001111/010000", sv, rv); end
    access3(WEN_READ, 32'h10, 32'd0, 1'b0, sv, rv, rd);
    checks++; if (sv !== 6'b001111 || rv !== 6'b010000) begin failures++; $display("FAIL wait_rd_timing stall=%b resp=%b exp=001111/010000", sv, rv); end
    checks++; if (rd !== 32'hA5A5_0F0F) begin failures++; $display("FAIL wait_rd got=%h exp=%h", rd, 32'hA5A5_0F0F); end
    access3(WEN_READ, 32'h10, 32'd0, 1'b1, sv, rv, rd);
    checks++; if (sv !== 6'b001111 || rv !== 6'b010000 || rd !== 32'hA5A5_0F0F) begin failures++; $display("FAIL wait_scramble stall=%b resp=%b got=%h exp=%h", sv, rv, rd, 32'hA5A5_0F0F); end
  endtask

  task automatic test_random3();
    logic [5:0] sv, rv; logic [31:0] rd;
    logic [3:0] w; logic [31:0] a;
    for (int i = 0; i < 16; i++) begin
      access3(WEN_WORD, 32'(i * 4), $urandom, 1'b1, sv, rv, rd);
      checks++; if (sv !== 6'b001111 || rv !== 6'b010000 || rd !== exp_rd3) begin failures++; $display("FAIL fill3 i=%0d stall=%b resp=%b got=%h exp=%h", i, sv, rv, rd, exp_rd3); end
    end
    for (int n = 0; n < 30; n++) begin
      w = rand_wen(); a = rand_addr();
      access3(w, a, $urandom, 1'b1, sv, rv, rd);
      checks++; if (sv !== 6'b001111 || rv !== 6'b010000 || rd !== exp_rd3) begin failures++; $display("FAIL rnd3 wen=%b addr=%h stall=%b resp=%b got=%h exp=%h", w, a, sv, rv, rd, exp_rd3); end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] sv, rv; logic [31:0] rd; logic [31:0] prior;
    prior = m3[widx(32'h20)];
    en3 = 1'b1; wen3 = WEN_WORD; addr3 = 32'h20; wdata3 = 32'h55;
    #1;
    checks++; if (stall3 !== 1'b1) begin failures++; $display("FAIL rstmid_req_stall got=%b exp=1", stall3); end
    @(negedge clk);
    rst = 1'b1; en3 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_rd0 = 32'd0; exp_rd3 = 32'd0;
    #1;
    checks++; if (stall3 !== 1'b0 || resp3 !== 1'b0) begin failures++; $display("FAIL rstmid_hs stall=%b resp=%b exp=00", stall3, resp3); end
    checks++; if (rdata3 !== 32'd0 || rdata0 !== 32'd0) begin failures++; $display("FAIL rstmid_rdata got=%h/%h exp=0", rdata3, rdata0); end
    repeat (4) begin
      @(negedge clk);
      checks++; if (resp3 !== 1'b0 || stall3 !== 1'b0) begin failures++; $display("FAIL rstmid_quiet resp=%b stall=%b exp=00", resp3, stall3); end
    end
    access3(WEN_READ, 32'h20, 32'd0, 1'b0, sv, rv, rd);
    checks++; if (rd !== prior) begin failures++; $display("FAIL rstmid_dropped got=%h exp=%h", rd, prior); end
  endtask

  initial begin
    test_reset();
    test_basic0();
    test_byte_lanes();
    test_wrap();
    test_back_to_back();
    test_random0();
    test_wait_timing();
    test_random3();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
